// File: rtl/median3x3_stream.sv
// Streaming 3x3 median filter with two internal line buffers.
// Four register stages: window, row sort, column reduce, output.
module median3x3_stream #(
  parameter int WIDTH = 8,
  parameter int IMG_W = 640
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sof,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_border
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] TWO  = CW'(2);

  typedef logic [WIDTH-1:0] px_t;

  logic          en;
  logic          acc;
  logic [CW-1:0] col;
  logic [CW-1:0] pcol;
  logic [1:0]    row;
  logic [1:0]    prow;

  px_t lb1 [IMG_W];
  px_t lb2 [IMG_W];
  px_t nv  [3];
  px_t win [3][3];

  logic v0, f0;
  px_t  c0;
  px_t  s1_mn [3];
  px_t  s1_md [3];
  px_t  s1_mx [3];
  logic v1, f1;
  px_t  c1;
  px_t  s2_a, s2_b, s2_c;
  logic v2, f2;
  px_t  c2;

  function automatic px_t mn2(px_t a, px_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic px_t mx2(px_t a, px_t b);
    return (a < b) ? b : a;
  endfunction

  function automatic px_t md3(px_t a, px_t b, px_t c);
    return mx2(mn2(a, b), mn2(mx2(a, b), c));
  endfunction

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign acc      = in_valid && en && reset;

  // Effective position of the incoming pixel; sof forces the origin.
  always_comb begin
    pcol  = in_sof ? '0 : col;
    prow  = in_sof ? '0 : row;
    nv[0] = lb2[pcol];
    nv[1] = lb1[pcol];
    nv[2] = in_data;
  end

  // Column wraps each line; row saturates at 2 once a full window exists.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col <= '0;
      row <= '0;
    end else if (acc) begin
      if (pcol == LAST) begin
        col <= '0;
        row <= (prow == 2'd2) ? 2'd2 : prow + 2'd1;
      end else begin
        col <= pcol + 1'b1;
        row <= prow;
      end
    end
  end

  // Line buffers age one line per write; contents only matter at row 2.
  always_ff @(posedge clock) begin
    if (acc) begin
      lb2[pcol] <= lb1[pcol];
      lb1[pcol] <= in_data;
    end
  end

  // Window shift registers plus the pixel carried for border passthrough.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      win <= '{default: '{default: '0}};
      v0  <= 1'b0;
      f0  <= 1'b0;
      c0  <= '0;
    end else if (en) begin
      v0 <= acc;
      if (acc) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
          win[r][2] <= nv[r];
        end
        f0 <= (prow == 2'd2) && (pcol >= TWO);
        c0 <= in_data;
      end
    end
  end

  // Sort each window row into min, med, max.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_mn <= '{default: '0};
      s1_md <= '{default: '0};
      s1_mx <= '{default: '0};
      v1    <= 1'b0;
      f1    <= 1'b0;
      c1    <= '0;
    end else if (en) begin
      for (int r = 0; r < 3; r++) begin
        s1_mn[r] <= mn2(mn2(win[r][0], win[r][1]), win[r][2]);
        s1_md[r] <= md3(win[r][0], win[r][1], win[r][2]);
        s1_mx[r] <= mx2(mx2(win[r][0], win[r][1]), win[r][2]);
      end
      v1 <= v0;
      f1 <= f0;
      c1 <= c0;
    end
  end

  // Reduce columns: max of mins, median of meds, min of maxes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s2_a <= '0;
      s2_b <= '0;
      s2_c <= '0;
      v2   <= 1'b0;
      f2   <= 1'b0;
      c2   <= '0;
    end else if (en) begin
      s2_a <= mx2(mx2(s1_mn[0], s1_mn[1]), s1_mn[2]);
      s2_b <= md3(s1_md[0], s1_md[1], s1_md[2]);
      s2_c <= mn2(mn2(s1_mx[0], s1_mx[1]), s1_mx[2]);
      v2   <= v1;
      f2   <= f1;
      c2   <= c1;
    end
  end

  // Final median or border passthrough into the output register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_border <= 1'b0;
    end else if (en) begin
      out_valid  <= v2;
      out_data   <= f2 ? md3(s2_a, s2_b, s2_c) : c2;
      out_border <= !f2;
    end
  end

endmodule
